// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Fixed-priority interrupt controller. It synchronises the request
//            lines, latches their rising edges, applies a mask, and runs a
//            req/ack/eoi handshake with the core, one interrupt in service.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int                 NUM_IRQ  = 8,
    parameter int                 ID_W     = 3,
    parameter logic [NUM_IRQ-1:0] MASK_RST = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] pending,
    output logic               int_req,
    output logic [ID_W-1:0]    int_num,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic               busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_svc  = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_IRQ-1:0] r_s1, r_s2, r_s3;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_int_req;
    logic [ID_W-1:0]    r_int_num;
    logic               r_busy;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_elig;
    logic [ID_W-1:0]    w_sel;
    logic               w_ack_take;

    assign w_edge     = r_s2 & ~r_s3;
    assign w_elig     = r_pending & ~r_mask;
    assign w_ack_take = (r_state == c_req) && int_ack;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_ack_take && (r_int_num == ID_W'(i));
        end
    end

    // Scan downward so the lowest set index is the one left in w_sel.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pending <= '0;
            r_mask    <= MASK_RST;
        end else begin
            r_s1      <= irq;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            // A new edge on a bit being acknowledged must survive the clear.
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_int_req <= 1'b0;
            r_int_num <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (|w_elig) begin
                        r_int_num <= w_sel;
                        r_int_req <= 1'b1;
                        r_state   <= c_req;
                    end
                end
                c_req: begin
                    if (int_ack) begin
                        r_int_req <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_svc;
                    end
                end
                c_svc: begin
                    if (int_eoi) begin
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_int_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= c_idle;
                end
            endcase
        end
    end

    assign mask    = r_mask;
    assign pending = r_pending;
    assign int_req = r_int_req;
    assign int_num = r_int_num;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed self-checking bench for irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       int_req;
    logic [2:0] int_num;
    logic       int_ack;
    logic       int_eoi;
    logic       busy;

    int r_tests  = 0;
    int r_failed = 0;

    irq_ctrl #(
        .NUM_IRQ  (8),
        .ID_W     (3),
        .MASK_RST (8'hFF)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .int_req    (int_req),
        .int_num    (int_num),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are observed 1 ns after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v;
        tick(1);
        irq = 8'h00;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        int_eoi = 1'b1;
        tick(1);
        int_eoi = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick(1);
        mask_we    = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        irq        = 8'h00;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        int_ack    = 1'b0;
        int_eoi    = 1'b0;
        tick(2);
        check("rst_mask",    32'(mask),    32'hFF);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_req",     32'(int_req), 32'h0);
        check("rst_num",     32'(int_num), 32'h0);
        check("rst_busy",    32'(busy),    32'h0);

        rst_n = 1'b1;
        write_mask(8'h00);
        check("mask_wr0", 32'(mask), 32'h00);

        // Single line 5: edge 0 samples the pulse.
        pulse_irq(8'h20);
        tick(2);
        check("t1_pending", 32'(pending), 32'h20);
        check("t1_req_early", 32'(int_req), 32'h0);
        tick(1);
        check("t1_req", 32'(int_req), 32'h1);
        check("t1_num", 32'(int_num), 32'h5);
        do_ack();
        check("t1_ack_pend", 32'(pending), 32'h00);
        check("t1_ack_busy", 32'(busy),    32'h1);
        check("t1_ack_req",  32'(int_req), 32'h0);
        do_eoi();
        check("t1_eoi_busy", 32'(busy), 32'h0);

        // Lines 6 and 2 together: 2 wins, 6 follows one cycle after EOI.
        pulse_irq(8'h44);
        tick(2);
        check("t2_pending", 32'(pending), 32'h44);
        tick(1);
        check("t2_req", 32'(int_req), 32'h1);
        check("t2_num", 32'(int_num), 32'h2);
        do_ack();
        check("t2_pend_after_ack", 32'(pending), 32'h40);
        do_eoi();
        check("t2_gap_req", 32'(int_req), 32'h0);
        tick(1);
        check("t2_req6", 32'(int_req), 32'h1);
        check("t2_num6", 32'(int_num), 32'h6);
        do_ack();
        do_eoi();

        // Committed request on line 4 holds against irq[1] and a mask write.
        pulse_irq(8'h10);
        tick(3);
        check("t3_req", 32'(int_num), 32'h4);
        irq        = 8'h02;
        mask_we    = 1'b1;
        mask_wdata = 8'h10;
        tick(1);
        mask_we = 1'b0;
        irq     = 8'h00;
        tick(3);
        check("t3_hold_req", 32'(int_req), 32'h1);
        check("t3_hold_num", 32'(int_num), 32'h4);
        check("t3_pending",  32'(pending), 32'h12);
        do_ack();
        check("t3_ack_pend", 32'(pending), 32'h02);
        do_eoi();
        tick(1);
        check("t3_req1", 32'(int_req), 32'h1);
        check("t3_num1", 32'(int_num), 32'h1);
        do_ack();
        do_eoi();

        // Fully masked line latches but does not request until unmasked.
        write_mask(8'hFF);
        pulse_irq(8'h08);
        tick(2);
        check("t4_pending", 32'(pending), 32'h08);
        tick(2);
        check("t4_masked_req", 32'(int_req), 32'h0);
        write_mask(8'h00);
        tick(1);
        check("t4_req", 32'(int_req), 32'h1);
        check("t4_num", 32'(int_num), 32'h3);
        do_ack();
        check("t4_busy", 32'(busy), 32'h1);
        do_eoi();

        // Spurious handshakes.
        do_ack();
        check("t5_idle_ack_busy", 32'(busy),    32'h0);
        check("t5_idle_ack_req",  32'(int_req), 32'h0);
        pulse_irq(8'h01);
        tick(3);
        check("t5_req0", 32'(int_req), 32'h1);
        do_eoi();
        check("t5_req_eoi_req",  32'(int_req), 32'h1);
        check("t5_req_eoi_busy", 32'(busy),    32'h0);
        int_ack = 1'b1;
        int_eoi = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_eoi = 1'b0;
        check("t5_both_busy", 32'(busy),    32'h1);
        check("t5_both_req",  32'(int_req), 32'h0);

        // Reset while in service, with another edge in flight.
        irq = 8'h80;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_busy",    32'(busy),    32'h0);
        check("t6_rst_req",     32'(int_req), 32'h0);
        check("t6_rst_num",     32'(int_num), 32'h0);
        check("t6_rst_pending", 32'(pending), 32'h00);
        check("t6_rst_mask",    32'(mask),    32'hFF);
        irq   = 8'h00;
        rst_n = 1'b1;
        tick(4);
        check("t6_post_pending", 32'(pending), 32'h00);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Sequencing interrupt controller between the eight external IRQ pins and the core's trap logic. It synchronises the asynchronous request lines and latches rising edges into a pending register. It applies a software-writable mask, selects one interrupt by fixed priority, and runs a request/acknowledge/end-of-interrupt handshake with the core. Only one interrupt is in service at a time; there is no nesting.

## Interface
- `NUM_IRQ`, 8: number of request lines; fixed-priority width.
- `ID_W`, 3: width of interrupt number; `2**ID_W >= NUM_IRQ`.
- `MASK_RST`, all ones: mask value after reset (1 = masked).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `irq`  in  NUM_IRQ  asynchronous request lines, active high.
- `mask_we`  in  1  write strobe for mask register.
- `mask_wdata`  in  NUM_IRQ  new mask value.
- `mask`  out  NUM_IRQ  current mask register.
- `pending`  out  NUM_IRQ  latched, not-yet-acknowledged edges.
- `int_req`  out  1  interrupt request to core.
- `int_num`  out  ID_W  number of the requested/in-service interrupt.
- `int_ack`  in  1  core accepts the request (1-cycle pulse).
- `int_eoi`  in  1  core finished the handler (1-cycle pulse).
- `busy`  out  1  an interrupt is in service.

## Operation
- Synchroniser: per line, `s1 <= irq`, `s2 <= s1`, `s3 <= s2`; `edge = s2 & ~s3`. All three stages reset to 0, so a line already high at reset release counts as one edge.
- Pending: on each clock, `pending <= (pending & ~clr) | edge`. `clr` is the one-hot bit of `int_num` when an ack is accepted. If set and clear hit the same bit in the same cycle, set wins.
- Mask: on `mask_we`, `mask <= mask_wdata`. The new mask is first used by the selection in the following cycle. Masked edges still latch into `pending`.
- Eligible vector: `pending & ~mask`. Selection picks the lowest set index (bit 0 = highest priority).
- FSM, states IDLE, REQ, SVC:
  - IDLE: if the eligible vector is non-zero, register the selected index into `int_num`, assert `int_req`, and go to REQ. Otherwise stay.
  - REQ: hold `int_req=1` and `int_num` stable regardless of new edges, mask writes or higher-priority arrivals; the request is committed. On `int_ack`: clear `pending[int_num]`, drop `int_req`, set `busy`, and go to SVC.
  - SVC: `int_num` holds the in-service number. On `int_eoi`: clear `busy` and go to IDLE.
- `int_ack` outside REQ and `int_eoi` outside SVC are ignored.
- `int_ack` and `int_eoi` asserted together in REQ: only the ack is taken; the FSM goes to SVC.
- Re-assertion of an in-service line while in SVC sets its pending bit; it is serviced after EOI.
- Reset mid-operation: state returns to IDLE. `pending`, sync stages, `int_req`, `busy` and `int_num` clear to 0. `mask` returns to `MASK_RST`.

## Timing
- Reset values: `int_req=0`, `int_num=0`, `busy=0`, `pending=0`, `mask=MASK_RST`.
- Latency: `irq` first sampled high at edge 0 → `pending` bit visible after edge 2 → `int_req` high after edge 3, provided the line is unmasked and the FSM is in IDLE.
- Ack sampled at edge k → `int_req=0`, `busy=1` and pending bit cleared after edge k.
- EOI sampled at edge k → IDLE after edge k. A further eligible pending bit raises `int_req` after edge k+1, so there is a minimum of one idle cycle between services.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Pulses on `irq` shorter than one clock period are not guaranteed to be captured.

## Test plan
- Reset with `mask_wdata=8'h00` written, pulse `irq[5]` → `pending=8'h20` after edge 2, `int_req=1` and `int_num=5` after edge 3. Ack → `pending=0`, `busy=1`. EOI → `busy=0`.
- Raise `irq[6]` and `irq[2]` in the same cycle → service `int_num=2` first. After its EOI, `int_num=6` is requested one cycle later.
- In REQ for line 4, raise `irq[1]` and write mask `8'h10` → `int_req` and `int_num=4` hold until ack. After EOI, line 1 is serviced.
- With `mask=8'hFF`, pulse `irq[3]` → `pending=8'h08`, `int_req` stays 0. Write mask `8'h00` → `int_req=1`, `int_num=3` within 2 cycles.
- Spurious `int_ack` in IDLE and `int_eoi` in REQ → no state change. Assert `rst_n=0` during SVC → all outputs return to reset values on the next edge.
